// File: rtl/hoene_protocol_frame_sequencer.sv
// hoene_protocol_frame_sequencer
// Receive-side frame controller. It sits between the protocol in-sync stage
// and the LED PWM/forwarding logic.
// The first frame after sync is assembled MSB first and parity-checked. If
// the check passes, the data field is committed as the duty value. Frames
// that follow in the same sync burst are passed to the next node in the chain.
// Optional feature macro: SEQ_ERROR_COUNTER_EN (saturating 4-bit error counter).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no sync; waiting for in_sync to rise
// HUNT    | sync seen, waiting for the first bit strobe of own frame
// RECV    | shifting in data + parity bits
// CHECK   | one cycle: even-parity check of the assembled frame
// COMMIT  | one cycle: pwm_set pulse, duty updated
// FORWARD | later frames of this burst are passed to fwd_clk/fwd_data
// DONE    | own frame committed, forwarding disabled; wait for sync loss
// ERROR   | parity or decoder error; wait for sync loss
module hoene_protocol_frame_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter bit FWD_ENABLE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_clk,
  input  logic                 in_data,
  input  logic                 in_sync,
  input  logic                 in_error,
  output logic [DATA_BITS-1:0] duty,
  output logic                 pwm_set,
  output logic                 frame_err,
  output logic [7:0]           frame_count,
  output logic                 busy,
  output logic                 fwd_clk,
  output logic                 fwd_data,
  output logic [3:0]           err_count
);

  localparam int FRAME_BITS = DATA_BITS + 1;
  localparam int CW         = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_RECV, S_CHECK, S_COMMIT, S_FORWARD, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [DATA_BITS-1:0]  duty_q, duty_d;
  logic                  pwm_set_q, pwm_set_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            frame_count_q, frame_count_d;
  logic                  busy_q, busy_d;
  logic                  fwd_clk_q, fwd_clk_d;
  logic                  fwd_data_q, fwd_data_d;

  assign cnt_inc = cnt_q + CW'(1);

  // Next-state and next-output logic. Sync loss has the highest priority,
  // then the decoder error, then the bit strobe.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    duty_d        = duty_q;
    pwm_set_d     = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    fwd_clk_d     = 1'b0;
    fwd_data_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_sync) state_d = S_HUNT;
      end
      S_HUNT: begin
        if (!in_sync) begin
          state_d = S_IDLE;
        end else if (in_error) begin
          state_d     = S_ERROR;
          frame_err_d = 1'b1;
        end else if (in_clk) begin
          state_d = S_RECV;
          shift_d = {shift_q[FRAME_BITS-2:0], in_data};
          cnt_d   = CW'(1);
        end
      end
      S_RECV: begin
        if (!in_sync) begin
          state_d = S_IDLE;
        end else if (in_error) begin
          state_d     = S_ERROR;
          frame_err_d = 1'b1;
        end else if (in_clk) begin
          shift_d = {shift_q[FRAME_BITS-2:0], in_data};
          cnt_d   = cnt_inc;
          if (cnt_inc == CW'(FRAME_BITS)) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!in_sync) begin
          state_d = S_IDLE;
        end else if (in_error || (^shift_q)) begin
          state_d     = S_ERROR;
          frame_err_d = 1'b1;
        end else begin
          // Outputs are registered, so they are visible during COMMIT.
          state_d       = S_COMMIT;
          duty_d        = shift_q[FRAME_BITS-1:1];
          pwm_set_d     = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end
      end
      S_COMMIT: begin
        state_d = FWD_ENABLE ? S_FORWARD : S_DONE;
      end
      S_FORWARD: begin
        if (!in_sync) begin
          state_d = S_IDLE;
        end else if (in_clk) begin
          fwd_clk_d  = 1'b1;
          fwd_data_d = in_data;
        end
      end
      S_DONE, S_ERROR: begin
        if (!in_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A partial frame is discarded whenever we fall back to IDLE.
    if (state_d == S_IDLE) begin
      shift_d = '0;
      cnt_d   = '0;
    end

    busy_d = (state_d == S_RECV) || (state_d == S_CHECK) || (state_d == S_COMMIT);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      duty_q        <= '0;
      pwm_set_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
      fwd_clk_q     <= 1'b0;
      fwd_data_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      duty_q        <= duty_d;
      pwm_set_q     <= pwm_set_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
      fwd_clk_q     <= fwd_clk_d;
      fwd_data_q    <= fwd_data_d;
    end
  end

`ifdef SEQ_ERROR_COUNTER_EN
  logic [3:0] err_cnt_q, err_cnt_d;

  // Saturating count of frame_err pulses; only rst_n clears it
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 4'hF)) err_cnt_d = err_cnt_q + 4'd1;
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 4'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 4'd0;
`endif

  assign duty        = duty_q;
  assign pwm_set     = pwm_set_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;
  assign fwd_clk     = fwd_clk_q;
  assign fwd_data    = fwd_data_q;

endmodule

// File: tb/tb_hoene_protocol_frame_sequencer.sv
// Directed bench for hoene_protocol_frame_sequencer. One instance forwards
// frames and a second instance has forwarding disabled. Both instances share
// the same stimulus.
module tb_hoene_protocol_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_clk = 1'b0;
  logic       in_data = 1'b0;
  logic       in_sync = 1'b0;
  logic       in_error = 1'b0;

  logic [7:0] duty, nf_duty;
  logic       pwm_set, nf_pwm_set;
  logic       frame_err, nf_frame_err;
  logic [7:0] frame_count, nf_frame_count;
  logic       busy, nf_busy;
  logic       fwd_clk, nf_fwd_clk;
  logic       fwd_data, nf_fwd_data;
  logic [3:0] err_count, nf_err_count;

  int n_cmp = 0;
  int n_bad = 0;

  int n_pwm = 0;
  int n_ferr = 0;
  int n_misalign = 0;
  int n_nf_fwd = 0;
  bit fwd_q[$];
  logic prev_in_clk = 1'b0;

`ifdef SEQ_ERROR_COUNTER_EN
  localparam bit ERR_CNT_EN = 1'b1;
`else
  localparam bit ERR_CNT_EN = 1'b0;
`endif

  hoene_protocol_frame_sequencer #(.DATA_BITS(8), .FWD_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_clk(in_clk), .in_data(in_data),
    .in_sync(in_sync), .in_error(in_error), .duty(duty), .pwm_set(pwm_set),
    .frame_err(frame_err), .frame_count(frame_count), .busy(busy),
    .fwd_clk(fwd_clk), .fwd_data(fwd_data), .err_count(err_count)
  );

  hoene_protocol_frame_sequencer #(.DATA_BITS(8), .FWD_ENABLE(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .in_clk(in_clk), .in_data(in_data),
    .in_sync(in_sync), .in_error(in_error), .duty(nf_duty), .pwm_set(nf_pwm_set),
    .frame_err(nf_frame_err), .frame_count(nf_frame_count), .busy(nf_busy),
    .fwd_clk(nf_fwd_clk), .fwd_data(nf_fwd_data), .err_count(nf_err_count)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (pwm_set) n_pwm++;
    if (frame_err) n_ferr++;
    if (fwd_clk) begin
      fwd_q.push_back(fwd_data);
      if (!prev_in_clk) n_misalign++;
    end
    if (nf_fwd_clk) n_nf_fwd++;
    prev_in_clk = in_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_pwm = 0;
    n_ferr = 0;
    n_misalign = 0;
    n_nf_fwd = 0;
    fwd_q.delete();
  endtask

  task automatic do_reset();
    in_clk = 1'b0;
    in_error = 1'b0;
    in_sync = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
  endtask

  // Strobes are 3 cycles apart. The task returns 1 time unit after the edge that sampled the strobe.
  task automatic send_bit(input logic b, input logic err);
    repeat (2) @(posedge clk);
    #1;
    in_clk = 1'b1;
    in_data = b;
    in_error = err;
    @(posedge clk);
    #1;
    in_clk = 1'b0;
    in_error = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
    send_bit(p, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {7'd0, duty, pwm_set, frame_err, frame_count, busy, fwd_clk, fwd_data, err_count};
  endfunction

  initial begin
    logic [8:0] fwd_bits;

    // Reset state
    do_reset();
    check("reset_outputs", all_outs(), 32'd0);

    // Good frame 0xA5, parity 0
    in_sync = 1'b1;
    send_frame(8'hA5, 1'b0);
    check("t1_check_busy", {31'd0, busy}, 32'd1);
    check("t1_check_no_pwm", {31'd0, pwm_set}, 32'd0);
    tick();
    check("t1_pwm_set", {31'd0, pwm_set}, 32'd1);
    check("t1_duty", {24'd0, duty}, 32'hA5);
    check("t1_frame_count", {24'd0, frame_count}, 32'd1);
    tick();
    check("t1_pwm_one_cycle", {31'd0, pwm_set}, 32'd0);
    check("t1_busy_low", {31'd0, busy}, 32'd0);
    check("t1_nf_duty", {24'd0, nf_duty}, 32'hA5);

    // Bad parity: error pulse one cycle after CHECK, then nothing until re-sync
    do_reset();
    in_sync = 1'b1;
    send_frame(8'hA5, 1'b1);
    check("t2_err_not_yet", {31'd0, frame_err}, 32'd0);
    tick();
    check("t2_frame_err", {31'd0, frame_err}, 32'd1);
    tick();
    check("t2_err_one_cycle", {31'd0, frame_err}, 32'd0);
    send_frame(8'h3C, 1'b0);
    repeat (3) tick();
    check("t2_no_forward", fwd_q.size(), 32'd0);
    check("t2_no_pwm", n_pwm, 32'd0);
    check("t2_duty_kept", {24'd0, duty}, 32'h00);
    in_sync = 1'b0;
    repeat (2) tick();
    in_sync = 1'b1;
    send_frame(8'hA5, 1'b0);
    repeat (3) tick();
    check("t2_resync_duty", {24'd0, duty}, 32'hA5);
    check("t2_err_pulses", n_ferr, 32'd1);

    // Sync loss after 4 bits discards the partial frame
    do_reset();
    in_sync = 1'b1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t3_busy_recv", {31'd0, busy}, 32'd1);
    in_sync = 1'b0;
    repeat (4) tick();
    check("t3_busy_idle", {31'd0, busy}, 32'd0);
    check("t3_no_pwm", n_pwm, 32'd0);
    check("t3_no_err", n_ferr, 32'd0);
    in_sync = 1'b1;
    send_frame(8'h3C, 1'b0);
    repeat (3) tick();
    check("t3_duty", {24'd0, duty}, 32'h3C);
    check("t3_frame_count", {24'd0, frame_count}, 32'd1);

    // Two frames in one burst: own frame committed, second one forwarded
    do_reset();
    in_sync = 1'b1;
    send_frame(8'hA5, 1'b0);
    send_frame(8'h3C, 1'b0);
    repeat (3) tick();
    check("t4_duty", {24'd0, duty}, 32'hA5);
    check("t4_frame_count", {24'd0, frame_count}, 32'd1);
    check("t4_fwd_pulses", fwd_q.size(), 32'd9);
    fwd_bits = '0;
    for (int i = 0; i < fwd_q.size() && i < 9; i++) fwd_bits = {fwd_bits[7:0], fwd_q[i]};
    check("t4_fwd_data", {23'd0, fwd_bits}, {23'd0, 9'b001111000});
    check("t4_fwd_latency", n_misalign, 32'd0);
    check("t4_nf_no_fwd", n_nf_fwd, 32'd0);
    check("t4_nf_duty", {24'd0, nf_duty}, 32'hA5);
    check("t4_pwm_pulses", n_pwm, 32'd1);

    // Decoder error on bit 5 (error wins over the strobe), then a run of error frames
    do_reset();
    in_sync = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    check("t5_frame_err", {31'd0, frame_err}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_err_count_1", {28'd0, err_count}, ERR_CNT_EN ? 32'd1 : 32'd0);
    for (int k = 0; k < 16; k++) begin
      in_sync = 1'b0;
      repeat (2) tick();
      in_sync = 1'b1;
      send_bit(1'b1, 1'b1);
    end
    repeat (3) tick();
    check("t5_err_pulses", n_ferr, 32'd17);
    check("t5_err_count_sat", {28'd0, err_count}, ERR_CNT_EN ? 32'd15 : 32'd0);
    check("t5_no_pwm", n_pwm, 32'd0);
    check("t5_duty", {24'd0, duty}, 32'h00);

    // Asynchronous reset mid-RECV
    do_reset();
    in_sync = 1'b1;
    send_frame(8'hA5, 1'b0);
    repeat (2) tick();
    in_sync = 1'b0;
    repeat (2) tick();
    in_sync = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t6_recv_busy", {31'd0, busy}, 32'd1);
    #3 rst_n = 1'b0;
    in_sync = 1'b0;
    #1 check("t6_async_rst_recv", all_outs(), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();

    // Asynchronous reset mid-FORWARD
    in_sync = 1'b1;
    send_frame(8'h5A, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t6_fwd_pulse", {31'd0, fwd_clk}, 32'd1);
    send_bit(1'b0, 1'b0);
    #3 rst_n = 1'b0;
    in_sync = 1'b0;
    #1 check("t6_async_rst_fwd", all_outs(), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();

    // Next burst runs normally
    in_sync = 1'b1;
    send_frame(8'h3C, 1'b0);
    repeat (3) tick();
    check("t6_after_duty", {24'd0, duty}, 32'h3C);
    check("t6_after_count", {24'd0, frame_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
